// File: rtl/ps2_key_rx_if.sv
// ps2_key_rx_if
//   Carries the decoded key-event word and status from the PS/2 receiver
//   to the keypad-matrix logic.
//
//   ps2_key   [10:0] {toggle, pressed, extended, code[7:0]}; bit 10 flips
//                    once per published key event, value held in between.
//   frame_err        one-cycle pulse on a framing, parity or timeout error.
//   busy             high while a frame is being shifted in.
//
//   master: the receiver (drives everything); slave: the consumer.
interface ps2_key_rx_if;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    modport master (output ps2_key, output frame_err, output busy);
    modport slave  (input  ps2_key, input  frame_err, input  busy);
endinterface

// File: rtl/ps2_key_rx.sv
// ps2_key_rx
//   PS/2 keyboard device-to-host receiver. Synchronizes and glitch-filters
//   the raw clock/data pins, frames 11-bit PS/2 characters, tracks the E0
//   (extended) and F0 (release) prefixes and publishes each finished key
//   event as a toggle-strobed 11-bit word.
//
//   Ports:
//     clk_sys     system clock (only clock)
//     reset_n     asynchronous active-low reset
//     ps2_clk_i   raw PS/2 clock pin (asynchronous)
//     ps2_data_i  raw PS/2 data pin (asynchronous)
//     key_bus     ps2_key_rx_if.master: ps2_key, frame_err, busy
module ps2_key_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ps2_clk_i,
    input  logic          ps2_data_i,
    ps2_key_rx_if.master  key_bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    localparam logic [7:0]  FLT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [19:0] TO_LIMIT = 20'(TIMEOUT);

    state_t      state, state_next;
    logic        clk_s1, clk_s2, data_s1, data_s2;
    logic        clk_filt;
    logic [7:0]  flt_cnt;
    logic        strobe;
    logic [9:0]  shreg;
    logic [3:0]  bit_cnt;
    logic [19:0] to_cnt;
    logic        ext, rel;
    logic [10:0] key;
    logic        err;

    logic        err_set, publish, set_ext, set_rel, clr_flags;
    logic [7:0]  rx_byte;
    logic        frame_ok;

    // Synchronizers idle high so a released line reads as "no activity".
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk_i;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_i;
            data_s2 <= data_s1;
        end
    end

    // The counter runs only while the synchronized clock disagrees with the
    // filtered level; any agreeing sample restarts it, so a run shorter than
    // FILTER_LEN never flips the level.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt <= 1'b1;
            flt_cnt  <= 8'd0;
        end else if (clk_s2 == clk_filt) begin
            flt_cnt <= 8'd0;
        end else if (flt_cnt == FLT_LAST) begin
            clk_filt <= clk_s2;
            flt_cnt  <= 8'd0;
        end else begin
            flt_cnt <= flt_cnt + 8'd1;
        end
    end

    // Strobe fires on the cycle the filtered level falls; data_s2 is the bit.
    assign strobe   = clk_filt && !clk_s2 && (flt_cnt == FLT_LAST);

    // shreg = {stop, parity, data[7:0]} once ten bits have been shifted in.
    assign rx_byte  = shreg[7:0];
    assign frame_ok = shreg[9] && (^shreg[8:0]);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        err_set    = 1'b0;
        publish    = 1'b0;
        set_ext    = 1'b0;
        set_rel    = 1'b0;
        clr_flags  = 1'b0;
        case (state)
            IDLE: begin
                if (strobe) begin
                    if (!data_s2) state_next = SHIFT;
                    else          err_set    = 1'b1;
                end
            end
            SHIFT: begin
                // A strobe wins over a timeout landing on the same cycle.
                if (strobe) begin
                    if (bit_cnt == 4'd10) state_next = CHECK;
                end else if (to_cnt == TO_LIMIT) begin
                    err_set    = 1'b1;
                    clr_flags  = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (!frame_ok) begin
                    err_set   = 1'b1;
                    clr_flags = 1'b1;
                end else begin
                    case (rx_byte)
                        8'hE0: set_ext = 1'b1;
                        8'hF0: set_rel = 1'b1;
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF:
                               clr_flags = 1'b1;
                        default: begin
                            publish   = 1'b1;
                            clr_flags = 1'b1;
                        end
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= 10'd0;
            bit_cnt <= 4'd0;
            to_cnt  <= 20'd0;
            ext     <= 1'b0;
            rel     <= 1'b0;
            key     <= 11'h000;
            err     <= 1'b0;
        end else begin
            if (state == SHIFT) begin
                if (strobe) begin
                    shreg   <= {data_s2, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    to_cnt  <= 20'd0;
                end else begin
                    to_cnt  <= to_cnt + 20'd1;
                end
            end else begin
                to_cnt <= 20'd0;
                if (state == IDLE && strobe && !data_s2) bit_cnt <= 4'd1;
            end

            if (clr_flags) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end else begin
                if (set_ext) ext <= 1'b1;
                if (set_rel) rel <= 1'b1;
            end

            if (publish) key <= {~key[10], ~rel, ext, rx_byte};
            err <= err_set;
        end
    end

    assign key_bus.ps2_key   = key;
    assign key_bus.frame_err = err;
    assign key_bus.busy      = (state == SHIFT);

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb_ps2_key_rx
//   Drives PS/2 frames into ps2_key_rx and checks published key events and
//   error pulses against an event-level model through a scoreboard queue.
module tb_ps2_key_rx;

    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int HALF = 12;

    logic clk_sys  = 1'b0;
    logic reset_n  = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_key_rx_if key_bus ();

    ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .key_bus    (key_bus)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic        is_err;
        logic [10:0] key;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;

    // Event-level model state
    bit          m_ext = 1'b0;
    bit          m_rel = 1'b0;
    logic [10:0] m_key = 11'h000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.key    = 11'h000;
        exp_q.push_back(e);
    endtask

    // What a keyboard host should report for one received character.
    task automatic model_frame(input logic [7:0] b, input bit good);
        exp_t e;
        if (!good) begin
            push_err();
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else begin
            m_key    = {~m_key[10], ~m_rel, m_ext, b};
            e.is_err = 1'b0;
            e.key    = m_key;
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    // One PS/2 bit: data set while clock high, optional short low glitch
    // during the high phase, then a full low phase.
    task automatic send_bit(input bit v, input bit glitch);
        @(negedge clk_sys);
        ps2_data = v;
        repeat (8) @(negedge clk_sys);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (FL - 1) @(negedge clk_sys);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i], glitch && (i == 5));
        repeat (3 * HALF) @(negedge clk_sys);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit glitch);
        model_frame(b, !bad_par);
        send_frame(b, bad_par, glitch);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 400) begin
            @(negedge clk_sys);
            waited++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops one expectation per toggle change or error cycle.
    initial begin : monitor
        logic prev_tog;
        exp_t e;
        prev_tog = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (reset_n && mon_en) begin
                if (key_bus.ps2_key[10] !== prev_tog) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected key event", 32'(key_bus.ps2_key), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("event kind (key)", 32'(e.is_err), 32'd0);
                        check("ps2_key", 32'(key_bus.ps2_key), 32'(e.key));
                    end
                end
                if (key_bus.frame_err === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected frame_err", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event kind (frame_err)", 32'(e.is_err), 32'd1);
                    end
                end
            end
            prev_tog = key_bus.ps2_key[10];
        end
    end

    initial begin : stimulus
        int r;
        logic [7:0] b;
        logic [7:0] resp [6];
        resp = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

        repeat (3) @(negedge clk_sys);
        check("reset ps2_key", 32'(key_bus.ps2_key), 32'h0);
        check("reset frame_err", 32'(key_bus.frame_err), 32'd0);
        check("reset busy", 32'(key_bus.busy), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        mon_en = 1'b1;

        // Make, break, extended and prefix orderings
        frame(8'h1C, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h1C, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'h75, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h75, 0, 0);
        frame(8'h75, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h74, 0, 0);

        // Parity error must clear a pending F0
        frame(8'hF0, 0, 0);
        frame(8'h16, 1, 0);
        frame(8'h16, 0, 0);

        // Device responses publish nothing and clear prefixes
        frame(8'hE0, 0, 0);
        frame(8'hAA, 0, 0);
        frame(8'hFA, 0, 0);
        frame(8'h1C, 0, 0);
        frame(8'hE1, 0, 0);

        // Invalid start: a lone clock pulse with data high
        push_err();
        send_bit(1'b1, 1'b0);
        repeat (3 * HALF) @(negedge clk_sys);
        drain("drain directed");

        // Timeout on a partial frame, with an E0 pending
        frame(8'hE0, 0, 0);
        push_err();
        m_ext = 1'b0;
        m_rel = 1'b0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        check("busy mid-frame", 32'(key_bus.busy), 32'd1);
        repeat (TO + 10) @(negedge clk_sys);
        check("busy after timeout", 32'(key_bus.busy), 32'd0);
        frame(8'h1E, 0, 0);

        // Glitch rejection while idle and mid-frame
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (FL - 1) @(negedge clk_sys);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk_sys);
            check("busy after idle glitch", 32'(key_bus.busy), 32'd0);
        end
        frame(8'h2B, 0, 1);
        frame(8'hE0, 0, 1);
        frame(8'h6B, 0, 1);
        drain("drain timeout/glitch");

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)       b = 8'hE0;
            else if (r < 4)  b = 8'hF0;
            else if (r == 4) b = resp[$urandom_range(0, 5)];
            else             b = 8'($urandom);
            frame(b, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
        end
        drain("drain random");

        // Make sure the word is non-zero before the reset test
        frame(8'h5A, 0, 0);
        drain("drain pre-reset");

        // Asynchronous reset in the middle of a frame
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk_sys);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset ps2_key", 32'(key_bus.ps2_key), 32'h0);
        check("async reset frame_err", 32'(key_bus.frame_err), 32'd0);
        check("async reset busy", 32'(key_bus.busy), 32'd0);
        m_key = 11'h000;
        m_ext = 1'b0;
        m_rel = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (FL + 6) @(negedge clk_sys);
        frame(8'h1C, 0, 0);
        drain("drain post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
